spi_target_bridge: RTL

- Responder end of the SPI controller's serial link.
- Deserialises controller frames (op flag, address, write data) into a parallel single-outstanding req/ack register-bus transaction.
- For reads, serialises the returned data back to the controller and signals completion with ready/op_done.
- Sits between the SPI link and any register block, so a peripheral can sit behind the controller without bespoke serial logic.

---
 rtl/spi_target_bridge.sv | 83 ++++++++
 1 files changed

// File: rtl/spi_target_bridge.sv
// spi_target_bridge: SPI responder that turns serial frames into single req/ack register-bus transactions
//   clk, rst            clock and asynchronous active-high reset
//   cs_n, mosi, miso    serial link (frame select, data in, read data out)
//   ready, op_done, err one-cycle pulses: read data follows / transaction complete / bus timeout
//   bus_req, bus_we     bus request and direction, held until ack or timeout
//   bus_addr, bus_wdata request address and write data, stable while bus_req=1
//   bus_ack, bus_rdata  bus acknowledge and read data (valid with ack)
module spi_target_bridge #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              ready,
    output logic              op_done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RDY, RDATA, DONE} state_t;
    localparam int MW = ADDR_W > DATA_W ? ADDR_W : DATA_W;
    localparam int CW = $clog2(MW + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [TW-1:0]     tcnt;
    logic              op;
    logic [DATA_W-1:0] rdata;
    logic              last_a, last_d, tout;
    assign last_a = cnt == CW'(ADDR_W - 1);
    assign last_d = cnt == CW'(DATA_W - 1);
    // ack in the final allowed cycle takes priority over the timeout
    assign tout = !bus_ack && tcnt == TW'(ACK_TIMEOUT - 1);
    assign bus_req = state == BUS;
    assign bus_we  = bus_req && op;
    assign ready   = state == RDY;
    assign op_done = state == DONE;
    assign miso    = state == RDATA && rdata[0];
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cs_n ? IDLE : ADDR;
            ADDR:    state_n = cs_n ? IDLE : last_a ? (op ? WDATA : BUS) : ADDR;
            WDATA:   state_n = cs_n ? IDLE : last_d ? BUS : WDATA;
            BUS:     state_n = bus_ack ? (op ? DONE : RDY) : tout ? IDLE : BUS;
            RDY:     state_n = RDATA;
            RDATA:   state_n = last_d ? DONE : RDATA;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // bit counter restarts on every state change, so each phase counts from zero
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt       <= '0;
            tcnt      <= '0;
            op        <= 1'b0;
            err       <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata     <= '0;
        end else begin
            cnt  <= state_n != state ? '0 : cnt + 1'b1;
            tcnt <= state == BUS ? tcnt + 1'b1 : '0;
            err  <= state == BUS && tout;
            if (state == IDLE && !cs_n) op <= mosi;
            if (state == ADDR && !cs_n) bus_addr <= ADDR_W'({mosi, bus_addr} >> 1);
            if (state == WDATA && !cs_n) bus_wdata <= DATA_W'({mosi, bus_wdata} >> 1);
            if (state == BUS && bus_ack) rdata <= bus_rdata;
            else if (state == RDATA) rdata <= rdata >> 1;
        end
endmodule
